// File: rtl/e203_itcm_loader.sv
// ITCM boot loader: takes a length-prefixed byte stream and packs it into 64-bit ITCM words,
// holding the core in reset and stall while the load runs.
// Optional trailing checksum byte: define E203_ITCM_LOADER_CKSUM_EN.
module e203_itcm_loader #(
  parameter int unsigned AW = 13,
  parameter int unsigned DP = 8192
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [7:0]    ram_wem,
  output logic [63:0]   ram_din,
  output logic          core_hold,
  output logic          done,
  output logic          err
);

`ifdef E203_ITCM_LOADER_CKSUM_EN
  typedef enum logic [2:0] {
    StIdle, StLen, StData, StFlush, StCksum, StDone, StErr
  } state_e;
  localparam state_e AfterData = StCksum;
`else
  typedef enum logic [2:0] {
    StIdle, StLen, StData, StFlush, StDone, StErr
  } state_e;
  localparam state_e AfterData = StDone;
`endif

  localparam logic [31:0] MaxBytes = 32'(DP * 8);

  state_e        state_q, state_d;
  logic [31:0]   cnt_q, len_q;
  logic [63:0]   wbuf_q;
  logic          rdy_d;
  logic          in_ready_q, ram_cs_q, ram_we_q, core_hold_q, done_q, err_q;
  logic [AW-1:0] ram_addr_q;
  logic [7:0]    ram_wem_q;
  logic [63:0]   ram_din_q;
`ifdef E203_ITCM_LOADER_CKSUM_EN
  logic [7:0]    sum_q;
`endif

  logic          xfer;
  logic [31:0]   len_full;
  logic [31:0]   cnt_inc;
  logic [2:0]    lane;
  logic          last_byte;
  logic          word_full;
  logic [63:0]   word_nxt;
  logic [7:0]    lane_mask;

  assign xfer      = in_valid & in_ready_q;
  assign len_full  = {in_data, len_q[23:0]};
  assign cnt_inc   = cnt_q + 32'd1;
  assign lane      = cnt_q[2:0];
  assign last_byte = (cnt_inc == len_q);
  assign word_full = (lane == 3'd7);
  // Lanes above the current one are still zero in wbuf_q, so a partial word is zero-padded.
  assign word_nxt  = wbuf_q | (64'(in_data) << {lane, 3'b000});
  assign lane_mask = 8'hFF >> (3'd7 - lane);

  assign in_ready  = in_ready_q;
  assign ram_cs    = ram_cs_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wem   = ram_wem_q;
  assign ram_din   = ram_din_q;
  assign core_hold = core_hold_q;
  assign done      = done_q;
  assign err       = err_q;

  // Next-state decode and the in_ready value that the next state implies.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StLen;
      StLen: begin
        if (xfer && cnt_q[1:0] == 2'd3) begin
          if (len_full > MaxBytes)     state_d = StErr;
          else if (len_full == 32'd0)  state_d = AfterData;
          else                         state_d = StData;
        end
      end
      StData:  if (xfer && last_byte) state_d = word_full ? AfterData : StFlush;
      StFlush: state_d = AfterData;
`ifdef E203_ITCM_LOADER_CKSUM_EN
      StCksum: if (xfer) state_d = (in_data == sum_q) ? StDone : StErr;
`endif
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    rdy_d = (state_d == StLen) || (state_d == StData);
`ifdef E203_ITCM_LOADER_CKSUM_EN
    if (state_d == StCksum) rdy_d = 1'b1;
`endif
  end

  // State register and registered outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      in_ready_q  <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wem_q   <= 8'h00;
      ram_din_q   <= 64'h0;
      core_hold_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= rdy_d;
      core_hold_q <= (state_d != StIdle) && (state_d != StErr);
      done_q      <= (state_d == StDone);
      if (state_d == StErr)                err_q <= 1'b1;
      else if (state_q == StIdle && start) err_q <= 1'b0;
      ram_cs_q <= 1'b0;
      ram_we_q <= 1'b0;
      // A full word writes while the stream continues; a partial last word writes in FLUSH.
      if (state_q == StData && xfer && (word_full || last_byte)) begin
        ram_cs_q   <= 1'b1;
        ram_we_q   <= 1'b1;
        ram_addr_q <= cnt_q[AW+2:3];
        ram_wem_q  <= lane_mask;
        ram_din_q  <= word_nxt;
      end
    end
  end

  // Byte counter, length capture, word assembly buffer and optional running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 32'd0;
      len_q  <= 32'd0;
      wbuf_q <= 64'h0;
`ifdef E203_ITCM_LOADER_CKSUM_EN
      sum_q  <= 8'h00;
`endif
    end else begin
      if (state_q == StIdle && start) begin
        cnt_q  <= 32'd0;
        len_q  <= 32'd0;
        wbuf_q <= 64'h0;
`ifdef E203_ITCM_LOADER_CKSUM_EN
        sum_q  <= 8'h00;
`endif
      end else if (state_q == StLen && xfer) begin
        len_q[{cnt_q[1:0], 3'b000} +: 8] <= in_data;
        cnt_q <= (cnt_q[1:0] == 2'd3) ? 32'd0 : cnt_inc;
      end else if (state_q == StData && xfer) begin
        cnt_q  <= cnt_inc;
        wbuf_q <= (word_full || last_byte) ? 64'h0 : word_nxt;
`ifdef E203_ITCM_LOADER_CKSUM_EN
        sum_q  <= sum_q + in_data;
`endif
      end
    end
  end

endmodule

// File: tb/tb_e203_itcm_loader.sv
// Directed bench for e203_itcm_loader; follows E203_ITCM_LOADER_CKSUM_EN when defined.
module tb_e203_itcm_loader;
  localparam int unsigned AW = 13;
  localparam int unsigned DP = 8192;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_ready, ram_cs, ram_we, core_hold, done, err;
  logic [AW-1:0] ram_addr;
  logic [7:0]    ram_wem;
  logic [63:0]   ram_din;

  e203_itcm_loader #(.AW(AW), .DP(DP)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wem(ram_wem), .ram_din(ram_din), .core_hold(core_hold), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [63:0] mem [16];
  logic [7:0]  wem_log [16];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM write observer.
  always @(negedge clk) begin
    if (ram_cs) begin
      wr_cnt++;
      mem[ram_addr[3:0]] = ram_din;
      wem_log[ram_addr[3:0]] = ram_wem;
      check("we_with_cs", 64'(ram_we), 64'd1);
    end
    if (done) done_cnt++;
  end

  task automatic clear_image();
    for (int i = 0; i < 16; i++) begin
      mem[i] = 64'h0;
      wem_log[i] = 8'h00;
    end
  endtask

  // Called at a negedge; returns at a negedge with in_valid low.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_len(input logic [31:0] n, input bit gap);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gap);
  endtask

  task automatic run_load(input logic [31:0] n, input logic [7:0] first, input bit gap,
                          input bit bad_ck, input bit poke);
    logic [7:0] s;
    s = 8'h00;
    start_pulse();
    check("hold_in_load", 64'(core_hold), 64'd1);
    check("err_cleared_by_start", 64'(err), 64'd0);
    send_len(n, gap);
    for (int k = 0; k < int'(n); k++) begin
      send_byte(first + 8'(k), gap);
      s = s + first + 8'(k);
      if (poke && k == 3) start_pulse();
    end
`ifdef E203_ITCM_LOADER_CKSUM_EN
    send_byte(bad_ck ? s + 8'd1 : s, gap);
`else
    if (bad_ck) s = 8'h00;
`endif
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (core_hold && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (t >= 30) check("idle_timeout", 64'd0, 64'd1);
    @(negedge clk);
  endtask

  int w0, d0;

  initial begin
    clear_image();
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_ram_cs", 64'(ram_cs), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_ram_addr", 64'(ram_addr), 64'd0);
    check("rst_ram_wem", 64'(ram_wem), 64'd0);
    check("rst_ram_din", ram_din, 64'd0);
    check("rst_core_hold", 64'(core_hold), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 16 bytes 00..0F: two full words
    clear_image(); w0 = wr_cnt; d0 = done_cnt;
    run_load(32'd16, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("l16_mem0", mem[0], 64'h0706050403020100);
    check("l16_mem1", mem[1], 64'h0F0E0D0C0B0A0908);
    check("l16_wem0", 64'(wem_log[0]), 64'hFF);
    check("l16_wem1", 64'(wem_log[1]), 64'hFF);
    check("l16_writes", 64'(wr_cnt - w0), 64'd2);
    check("l16_done", 64'(done_cnt - d0), 64'd1);
    check("l16_hold", 64'(core_hold), 64'd0);
    check("l16_err", 64'(err), 64'd0);

    // 11 bytes 10..1A: full word then flushed partial word
    clear_image(); w0 = wr_cnt; d0 = done_cnt;
    run_load(32'd11, 8'h10, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("l11_mem0", mem[0], 64'h1716151413121110);
    check("l11_wem0", 64'(wem_log[0]), 64'hFF);
    check("l11_mem1", mem[1], 64'h00000000001A1918);
    check("l11_wem1", 64'(wem_log[1]), 64'h07);
    check("l11_writes", 64'(wr_cnt - w0), 64'd2);
    check("l11_done", 64'(done_cnt - d0), 64'd1);

    // zero length: no writes, still completes
    w0 = wr_cnt; d0 = done_cnt;
    run_load(32'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("l0_writes", 64'(wr_cnt - w0), 64'd0);
    check("l0_done", 64'(done_cnt - d0), 64'd1);

    // oversize length 0x00010001 > 65536 bytes
    w0 = wr_cnt; d0 = done_cnt;
    start_pulse();
    send_len(32'h00010001, 1'b0);
    wait_idle();
    check("big_err", 64'(err), 64'd1);
    check("big_hold", 64'(core_hold), 64'd0);
    check("big_writes", 64'(wr_cnt - w0), 64'd0);
    check("big_no_done", 64'(done_cnt - d0), 64'd0);
    repeat (2) @(negedge clk);
    check("big_err_sticky", 64'(err), 64'd1);
    check("big_idle_ready", 64'(in_ready), 64'd0);

    // reset after payload byte 5 of a 16-byte load
    w0 = wr_cnt;
    start_pulse();
    send_len(32'd16, 1'b0);
    for (int k = 0; k < 5; k++) send_byte(8'(k), 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 64'(in_ready), 64'd0);
    check("mid_rst_hold", 64'(core_hold), 64'd0);
    check("mid_rst_cs", 64'(ram_cs), 64'd0);
    check("mid_rst_err", 64'(err), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("mid_rst_writes", 64'(wr_cnt - w0), 64'd0);
    check("mid_rst_idle", 64'(in_ready), 64'd0);

    // fresh load with random gaps and a start during DATA
    clear_image(); w0 = wr_cnt; d0 = done_cnt;
    run_load(32'd16, 8'h00, 1'b1, 1'b0, 1'b1);
    wait_idle();
    check("gap_mem0", mem[0], 64'h0706050403020100);
    check("gap_mem1", mem[1], 64'h0F0E0D0C0B0A0908);
    check("gap_writes", 64'(wr_cnt - w0), 64'd2);
    check("gap_done", 64'(done_cnt - d0), 64'd1);

`ifdef E203_ITCM_LOADER_CKSUM_EN
    // 01 02 03 with checksum 06 then 07
    d0 = done_cnt;
    run_load(32'd3, 8'h01, 1'b0, 1'b0, 1'b0);
    wait_idle();
    check("ck_ok_done", 64'(done_cnt - d0), 64'd1);
    check("ck_ok_err", 64'(err), 64'd0);
    check("ck_ok_mem0", mem[0], 64'h0000000000030201);
    d0 = done_cnt;
    run_load(32'd3, 8'h01, 1'b0, 1'b1, 1'b0);
    wait_idle();
    check("ck_bad_err", 64'(err), 64'd1);
    check("ck_bad_no_done", 64'(done_cnt - d0), 64'd0);
    check("ck_bad_mem0", mem[0], 64'h0000000000030201);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
